// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan receiver: segment positions,
// hex glyph patterns and receiver FSM state encodings.
package sevenseg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned TO_W       = 16;

  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  localparam logic [SEG_W-1:0] BIT_A  = SEG_W'(1) << SEG_A;
  localparam logic [SEG_W-1:0] BIT_B  = SEG_W'(1) << SEG_B;
  localparam logic [SEG_W-1:0] BIT_C  = SEG_W'(1) << SEG_C;
  localparam logic [SEG_W-1:0] BIT_D  = SEG_W'(1) << SEG_D;
  localparam logic [SEG_W-1:0] BIT_E  = SEG_W'(1) << SEG_E;
  localparam logic [SEG_W-1:0] BIT_F  = SEG_W'(1) << SEG_F;
  localparam logic [SEG_W-1:0] BIT_G  = SEG_W'(1) << SEG_G;
  localparam logic [SEG_W-1:0] BIT_DP = SEG_W'(1) << SEG_DP;

  // Hex glyphs with the decimal point clear
  localparam logic [SEG_W-1:0] GLYPH_0 = BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F;
  localparam logic [SEG_W-1:0] GLYPH_1 = BIT_B | BIT_C;
  localparam logic [SEG_W-1:0] GLYPH_2 = BIT_A | BIT_B | BIT_D | BIT_E | BIT_G;
  localparam logic [SEG_W-1:0] GLYPH_3 = BIT_A | BIT_B | BIT_C | BIT_D | BIT_G;
  localparam logic [SEG_W-1:0] GLYPH_4 = BIT_B | BIT_C | BIT_F | BIT_G;
  localparam logic [SEG_W-1:0] GLYPH_5 = BIT_A | BIT_C | BIT_D | BIT_F | BIT_G;
  localparam logic [SEG_W-1:0] GLYPH_6 = BIT_A | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
  localparam logic [SEG_W-1:0] GLYPH_7 = BIT_A | BIT_B | BIT_C;
  localparam logic [SEG_W-1:0] GLYPH_8 = BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
  localparam logic [SEG_W-1:0] GLYPH_9 = BIT_A | BIT_B | BIT_C | BIT_D | BIT_F | BIT_G;
  localparam logic [SEG_W-1:0] GLYPH_A = BIT_A | BIT_B | BIT_C | BIT_E | BIT_F | BIT_G;
  localparam logic [SEG_W-1:0] GLYPH_B = BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
  localparam logic [SEG_W-1:0] GLYPH_C = BIT_A | BIT_D | BIT_E | BIT_F;
  localparam logic [SEG_W-1:0] GLYPH_D = BIT_B | BIT_C | BIT_D | BIT_E | BIT_G;
  localparam logic [SEG_W-1:0] GLYPH_E = BIT_A | BIT_D | BIT_E | BIT_F | BIT_G;
  localparam logic [SEG_W-1:0] GLYPH_F = BIT_A | BIT_E | BIT_F | BIT_G;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } scan_state_t;

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Combinational seven-segment pattern to hex nibble decoder; the decimal
// point is ignored and unrecognised patterns give nibble 0 with valid low.
module sevenseg_glyph_decode
  import sevenseg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [NIB_W-1:0] nibble_c,
  output logic             valid_c
);

  logic [SEG_W-1:0] key_c;

  always_comb begin
    key_c    = pattern & ~BIT_DP;
    nibble_c = 4'h0;
    valid_c  = 1'b1;
    case (key_c)
      GLYPH_0: nibble_c = 4'h0;
      GLYPH_1: nibble_c = 4'h1;
      GLYPH_2: nibble_c = 4'h2;
      GLYPH_3: nibble_c = 4'h3;
      GLYPH_4: nibble_c = 4'h4;
      GLYPH_5: nibble_c = 4'h5;
      GLYPH_6: nibble_c = 4'h6;
      GLYPH_7: nibble_c = 4'h7;
      GLYPH_8: nibble_c = 4'h8;
      GLYPH_9: nibble_c = 4'h9;
      GLYPH_A: nibble_c = 4'hA;
      GLYPH_B: nibble_c = 4'hB;
      GLYPH_C: nibble_c = 4'hC;
      GLYPH_D: nibble_c = 4'hD;
      GLYPH_E: nibble_c = 4'hE;
      GLYPH_F: nibble_c = 4'hF;
      default: valid_c  = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_rx.sv
// Receiver for an 8-digit multiplexed seven-segment scan bus: rebuilds the
// per-digit segment bytes, flags bus errors and reports frame completion.
// Optional hex decode is enabled by defining SEVENSEG_RX_HEX_DECODE_EN.
module sevenseg_scan_rx
  import sevenseg_pkg::*;
#(
  parameter bit          COM_ACTIVE_LOW = 1'b1,
  parameter int unsigned SETTLE_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC    = 65535
) (
  input  logic                        iCLK,
  input  logic                        nRST,
  input  logic [NUM_DIGITS-1:0]       iS_COM,
  input  logic [SEG_W-1:0]            iS_ENS,
  output logic [NUM_DIGITS*SEG_W-1:0] oSEG_RAW,
  output logic [NUM_DIGITS*NIB_W-1:0] oHEX,
  output logic [NUM_DIGITS-1:0]       oHEX_VLD,
  output logic                        oFRAME,
  output logic                        oERR,
  output logic                        oSTALE
);

  localparam logic [NUM_DIGITS-1:0] COM_IDLE    = COM_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [TO_W-1:0]       TIMEOUT_MAX = TO_W'(TIMEOUT_CYC);

  logic [NUM_DIGITS-1:0] com_s1, com_s2, sel_q;
  logic [SEG_W-1:0]      ens_s1, ens_s2, ens_q;
  logic [NUM_DIGITS-1:0] sel_c;
  logic                  changed_c;
  scan_state_t           state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  write_c, err_set_c, frame_due_c;
  logic [NUM_DIGITS-1:0] seen;
  logic [TO_W-1:0]       to_cnt;

  // Synchronizer plus one-cycle history for change detection; COM idles inactive
  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) begin
      com_s1 <= COM_IDLE;
      com_s2 <= COM_IDLE;
      ens_s1 <= '0;
      ens_s2 <= '0;
      sel_q  <= '0;
      ens_q  <= '0;
    end else begin
      com_s1 <= iS_COM;
      com_s2 <= com_s1;
      ens_s1 <= iS_ENS;
      ens_s2 <= ens_s1;
      sel_q  <= sel_c;
      ens_q  <= ens_s2;
    end
  end

  assign sel_c     = COM_ACTIVE_LOW ? ~com_s2 : com_s2;
  assign changed_c = (sel_c != sel_q) || (ens_s2 != ens_q);

  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (sel_c != '0) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        if (sel_c == '0)              state_nxt = ST_IDLE;
        else if (changed_c)           cnt_nxt   = '0;
        else if (cnt == SETTLE_LAST)  state_nxt = ST_CAPTURE;
        else                          cnt_nxt   = cnt + 8'd1;
      end
      // A change during the capture cycle restarts settling instead of being lost
      ST_CAPTURE, ST_HOLD: begin
        if (changed_c) begin
          state_nxt = (sel_c != '0) ? ST_SETTLE : ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = ST_HOLD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture uses the held copies, which equal the value that just settled
  always_comb begin
    write_c   = 1'b0;
    err_set_c = 1'b0;
    if (state == ST_CAPTURE) begin
      write_c   = $onehot(sel_q);
      err_set_c = !$onehot(sel_q);
    end
  end

  assign frame_due_c = (seen == '1);

  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) begin
      oSEG_RAW <= '0;
      seen     <= '0;
      oFRAME   <= 1'b0;
      oERR     <= 1'b0;
      to_cnt   <= '0;
      oSTALE   <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_DIGITS; n++) begin
        if (write_c && sel_q[n]) oSEG_RAW[SEG_W*n +: SEG_W] <= ens_q;
      end
      oFRAME <= frame_due_c;
      seen   <= (frame_due_c ? '0 : seen) | (write_c ? sel_q : '0);
      if (err_set_c) oERR <= 1'b1;
      if (write_c) begin
        to_cnt <= '0;
        oSTALE <= 1'b0;
      end else if (to_cnt != TIMEOUT_MAX) begin
        to_cnt <= to_cnt + 16'd1;
        oSTALE <= (to_cnt + 16'd1 == TIMEOUT_MAX);
      end
    end
  end

`ifdef SEVENSEG_RX_HEX_DECODE_EN
  logic [NIB_W-1:0] nib_c;
  logic             vld_c;

  sevenseg_glyph_decode u_decode (
    .pattern  (ens_q),
    .nibble_c (nib_c),
    .valid_c  (vld_c)
  );

  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) begin
      oHEX     <= '0;
      oHEX_VLD <= '0;
    end else begin
      for (int n = 0; n < NUM_DIGITS; n++) begin
        if (write_c && sel_q[n]) begin
          oHEX[NIB_W*n +: NIB_W] <= nib_c;
          oHEX_VLD[n]            <= vld_c;
        end
      end
    end
  end
`else
  assign oHEX     = '0;
  assign oHEX_VLD = '0;
`endif

endmodule
